// File: rtl/ramp_adc_controller.sv
// ---------------------------------------------------------------------------
// ramp_adc_controller
//
// Control and capture FSM for a PWM-ramp single-slope ADC. An external
// pwm_ramp block raises its duty cycle. The RC-filtered PWM is compared
// against the analog input by an LVDS comparator (lvds_i=1 means the
// filtered ramp is above the input). This block:
//   - restarts each ramp,
//   - waits for the filter to discharge,
//   - detects a debounced comparator crossing,
//   - latches the duty cycle at that crossing as the conversion result,
//   - reports 0 when the input is below the ramp floor and full scale
//     when the ramp wraps without a crossing.
//
// Optional feature macro: ADC_AVG_EN
//   defined   : adc_value_o is the floor of the mean of the last 4 results
//   undefined : adc_value_o is the raw result of the latest conversion
//
// Ports
//   clk_i              in   1      clock, all logic on the rising edge
//   rst_i              in   1      asynchronous reset, active-high
//   lvds_i             in   1      comparator output, asynchronous to clk_i
//   pwm_dc_i           in   NBITS  current duty cycle from the ramp generator
//   adc_value_o        out  NBITS  last conversion result, held between conversions
//   adc_valid_o        out  1      one-cycle pulse when adc_value_o updates
//   clear_pwm_count_o  out  1      one-cycle pulse that restarts the ramp
// ---------------------------------------------------------------------------
module ramp_adc_controller #(
    parameter int NBITS          = 6,
    parameter int SYNC_STAGES    = 2,
    parameter int DEB_CYCLES     = 16,
    parameter int HOLDOFF_CYCLES = 4096
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             lvds_i,
    input  logic [NBITS-1:0] pwm_dc_i,
    output logic [NBITS-1:0] adc_value_o,
    output logic             adc_valid_o,
    output logic             clear_pwm_count_o
);

    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_MAX    = DEB_W'(DEB_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLDOFF_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(HOLDOFF_CYCLES);
    localparam logic [NBITS-1:0]  FULL_SCALE = '1;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_HOLDOFF,
        ST_RAMP,
        ST_CAPTURE
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvds_s;
    logic [NBITS-1:0]       prev_dc;
    logic [HOLD_W-1:0]      hold_cnt;
    logic [DEB_W-1:0]       deb_cnt;
    logic [NBITS-1:0]       result;
    logic [NBITS-1:0]       value_next;

    logic hold_done;
    logic deb_accept;
    logic dc_wrapped;
    logic clear_d;
    logic valid_d;

    // Metastability filter for the asynchronous comparator output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], lvds_i};
        end
    end

    assign lvds_s = sync_q[SYNC_STAGES-1];

    // The crossing is accepted on the DEB_CYCLES-th consecutive high sample,
    // so the decision uses the count before this cycle's increment.
    assign hold_done  = (hold_cnt == HOLD_LAST);
    assign deb_accept = lvds_s && (deb_cnt == DEB_LAST);
    assign dc_wrapped = (pwm_dc_i < prev_dc);

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. In RAMP a crossing and a wrap in the same cycle both
    // lead to CAPTURE; which result is stored is resolved in the result register.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_CLEAR: begin
                state_next = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (hold_done) begin
                    state_next = lvds_s ? ST_CAPTURE : ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (deb_accept || dc_wrapped) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_next = ST_CLEAR;
            end
            default: begin
                state_next = ST_CLEAR;
            end
        endcase
    end

    // Output decode; the pulses are registered below so they are glitch-free
    // and read 0 while reset is held.
    always_comb begin
        clear_d = 1'b0;
        valid_d = 1'b0;
        unique case (state)
            ST_CLEAR:   clear_d = 1'b1;
            ST_CAPTURE: valid_d = 1'b1;
            default: begin
                clear_d = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // Holdoff and debounce counters; both saturate instead of wrapping.
    // Any low sample in RAMP restarts the debounce window.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_cnt <= '0;
            deb_cnt  <= '0;
        end else begin
            if (state == ST_HOLDOFF) begin
                if (hold_cnt != HOLD_MAX) begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                end
            end else begin
                hold_cnt <= '0;
            end

            if ((state == ST_RAMP) && lvds_s) begin
                if (deb_cnt != DEB_MAX) begin
                    deb_cnt <= deb_cnt + DEB_W'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // Previous duty cycle, used to spot the ramp wrapping to zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_dc <= '0;
        end else begin
            prev_dc <= pwm_dc_i;
        end
    end

    // Conversion result. A crossing takes priority over a simultaneous wrap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result <= '0;
        end else begin
            if ((state == ST_HOLDOFF) && hold_done && lvds_s) begin
                result <= '0;
            end else if (state == ST_RAMP) begin
                if (deb_accept) begin
                    result <= pwm_dc_i;
                end else if (dc_wrapped) begin
                    result <= FULL_SCALE;
                end
            end
        end
    end

`ifdef ADC_AVG_EN
    logic [NBITS-1:0] hist_q [4];
    logic [NBITS+1:0] acc_q;
    logic [NBITS+1:0] acc_next;

    // Running sum of the last four results: add the newest, drop the oldest.
    always_comb begin
        acc_next = acc_q + {2'b00, result} - {2'b00, hist_q[3]};
    end

    // Four-entry history, starting from zeros so early averages are diluted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist_q[0] <= '0;
            hist_q[1] <= '0;
            hist_q[2] <= '0;
            hist_q[3] <= '0;
            acc_q     <= '0;
        end else if (valid_d) begin
            hist_q[0] <= result;
            hist_q[1] <= hist_q[0];
            hist_q[2] <= hist_q[1];
            hist_q[3] <= hist_q[2];
            acc_q     <= acc_next;
        end
    end

    assign value_next = acc_next[NBITS+1:2];
`else
    assign value_next = result;
`endif

    // Registered outputs; the value only moves on the CAPTURE cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            adc_value_o       <= '0;
            adc_valid_o       <= 1'b0;
            clear_pwm_count_o <= 1'b0;
        end else begin
            adc_valid_o       <= valid_d;
            clear_pwm_count_o <= clear_d;
            if (valid_d) begin
                adc_value_o <= value_next;
            end
        end
    end

endmodule

// File: tb/tb_ramp_adc_controller.sv
// ---------------------------------------------------------------------------
// tb_ramp_adc_controller
//
// Self-checking bench for ramp_adc_controller. The bench plays the part of
// the ramp generator and the analog front end: the duty cycle restarts at 0
// on every clear pulse and climbs one step every STEP cycles, and the
// comparator reads 1 whenever the duty cycle exceeds the analog input
// level vin (vin = -1 models an input below the ramp floor). Short high
// glitches can be injected below the crossing point. Expected results are
// derived from vin alone, with an optional four-deep average.
// ---------------------------------------------------------------------------
module tb_ramp_adc_controller;

    localparam int NBITS          = 6;
    localparam int SYNC_STAGES    = 2;
    localparam int DEB_CYCLES     = 16;
    localparam int HOLDOFF_CYCLES = 40;
    localparam int STEP           = 48;
    localparam int FULL           = (1 << NBITS) - 1;
    localparam int WAIT_LIMIT     = (FULL + 3) * STEP + HOLDOFF_CYCLES + 200;

`ifdef ADC_AVG_EN
    localparam int AVG_FOURTH = 26;
`else
    localparam int AVG_FOURTH = 32;
`endif

    logic             clk    = 1'b0;
    logic             rst    = 1'b0;
    logic             lvds   = 1'b0;
    logic [NBITS-1:0] pwm_dc = '0;
    logic [NBITS-1:0] adc_value;
    logic             adc_valid;
    logic             clear_pwm;

    ramp_adc_controller #(
        .NBITS          (NBITS),
        .SYNC_STAGES    (SYNC_STAGES),
        .DEB_CYCLES     (DEB_CYCLES),
        .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .lvds_i            (lvds),
        .pwm_dc_i          (pwm_dc),
        .adc_value_o       (adc_value),
        .adc_valid_o       (adc_valid),
        .clear_pwm_count_o (clear_pwm)
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    int cycle = 0;
    int obs_value = 0;
    bit obs_valid = 1'b0;
    bit obs_clear = 1'b0;

    int vin = 0;
    int dc = 0;
    int tick = 0;
    bit in_reset = 1'b0;
    bit glitch_armed = 1'b0;
    int glitch_dc = 0;
    int glitch_len = 0;
    int glitch_left = 0;
    bit real_prev = 1'b0;
    int rise_cycle = -1;
    int wrap_cycle = -1;

    int hist[$];
    int last_out = 0;

    // Compare one observed value with its expected value and keep the tally.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks_total++;
        if (actual == expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cycle);
        end
    endtask

    // Advance one clock, sample the DUT, then drive the ramp and comparator
    // for the next edge.
    task automatic applyStimulus();
        bit real_now;
        @(posedge clk);
        #1;
        cycle++;
        obs_value = int'(adc_value);
        obs_valid = adc_valid;
        obs_clear = clear_pwm;

        if (obs_clear) begin
            dc   = 0;
            tick = 0;
        end else begin
            tick++;
            if (tick == STEP) begin
                tick = 0;
                if (dc == FULL) begin
                    dc = 0;
                    wrap_cycle = cycle;
                end else begin
                    dc++;
                end
            end
        end

        if (glitch_armed && dc == glitch_dc && tick == 4) begin
            glitch_armed = 1'b0;
            glitch_left  = glitch_len;
        end

        real_now = (vin < 0) || (dc > vin);
        if (real_now && !real_prev) begin
            rise_cycle = cycle;
        end
        real_prev = real_now;

        pwm_dc = NBITS'(dc);
        if (in_reset) begin
            lvds = 1'($urandom);
        end else if (glitch_left > 0) begin
            lvds = 1'b1;
            glitch_left--;
        end else begin
            lvds = real_now;
        end
    endtask

    // Assert reset for n cycles with a noisy comparator, then release and
    // expect the restart pulse on the first cycle.
    task automatic doReset(input int n);
        rst = 1'b1;
        in_reset = 1'b1;
        #1;
        checkOutput("rst_async_value", int'(adc_value), 0);
        checkOutput("rst_async_valid", int'(adc_valid), 0);
        checkOutput("rst_async_clear", int'(clear_pwm), 0);
        repeat (n) applyStimulus();
        checkOutput("rst_hold_value", obs_value, 0);
        checkOutput("rst_hold_clear", int'(obs_clear), 0);
        hist = '{0, 0, 0, 0};
        last_out = 0;
        glitch_armed = 1'b0;
        glitch_left = 0;
        rst = 1'b0;
        in_reset = 1'b0;
        applyStimulus();
        checkOutput("clear_after_reset", int'(obs_clear), 1);
        checkOutput("valid_after_reset", int'(obs_valid), 0);
    endtask

    // Run one conversion with analog level v and an optional glitch of glen
    // cycles at duty cycle gdc, then check value, timing and pulses.
    task automatic runConversion(input int v, input int gdc, input int glen);
        int n;
        int clear_cycle;
        int valid_cycle;
        int extra_clear;
        int value_moved;
        int exp_result;
        int exp_out;

        n = 0;
        while (!obs_clear && n < WAIT_LIMIT) begin
            applyStimulus();
            n++;
        end
        if (!obs_clear) begin
            checkOutput("clear_timeout", 0, 1);
            return;
        end

        vin          = v;
        glitch_dc    = gdc;
        glitch_len   = glen;
        glitch_armed = (glen > 0);
        glitch_left  = 0;
        rise_cycle   = -1;
        wrap_cycle   = -1;
        clear_cycle  = cycle;

        applyStimulus();
        checkOutput("clear_width", int'(obs_clear), 0);

        n = 1;
        extra_clear = 0;
        value_moved = 0;
        while (!obs_valid && n < WAIT_LIMIT) begin
            if (obs_clear) extra_clear++;
            if (obs_value != last_out) value_moved++;
            applyStimulus();
            n++;
        end
        if (!obs_valid) begin
            checkOutput("valid_timeout", 0, 1);
            return;
        end
        valid_cycle = cycle;

        if (v < 0) begin
            exp_result = 0;
        end else if (v >= FULL) begin
            exp_result = FULL;
        end else begin
            exp_result = v + 1;
        end
        hist.push_front(exp_result);
        void'(hist.pop_back());
`ifdef ADC_AVG_EN
        exp_out = (hist[0] + hist[1] + hist[2] + hist[3]) / 4;
`else
        exp_out = exp_result;
`endif

        checkOutput("adc_value", obs_value, exp_out);
        checkOutput("no_early_clear", extra_clear, 0);
        checkOutput("value_held", value_moved, 0);

        if (v < 0) begin
            checkOutput("stuck_latency", valid_cycle - clear_cycle, HOLDOFF_CYCLES + 1);
        end else if (v >= FULL) begin
            checkOutput("wrap_latency", valid_cycle - wrap_cycle, 2);
        end else begin
            checkOutput("cross_latency", valid_cycle - rise_cycle, SYNC_STAGES + DEB_CYCLES + 1);
        end
        last_out = exp_out;

        applyStimulus();
        checkOutput("valid_width", int'(obs_valid), 0);
        checkOutput("clear_after_valid", int'(obs_clear), 1);
        checkOutput("value_stable", obs_value, exp_out);
    endtask

    // Start a conversion and pull reset part-way through the ramp.
    task automatic abortConversion();
        int n;
        n = 0;
        while (!obs_clear && n < WAIT_LIMIT) begin
            applyStimulus();
            n++;
        end
        vin = 50;
        glitch_armed = 1'b0;
        repeat (HOLDOFF_CYCLES + 300) applyStimulus();
        checkOutput("abort_no_valid_yet", int'(obs_valid), 0);
        doReset(5);
    endtask

    // Random conversions, with a glitch below the crossing about half the time.
    task automatic randomConversions(input int count);
        int v;
        int gdc;
        int glen;
        for (int i = 0; i < count; i++) begin
            v = int'($urandom_range(0, FULL + 1)) - 1;
            gdc = 0;
            glen = 0;
            if (v >= 1 && $urandom_range(0, 1) == 1) begin
                gdc  = int'($urandom_range(1, v));
                glen = int'($urandom_range(1, DEB_CYCLES - 3));
            end
            runConversion(v, gdc, glen);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit (cycle %0d)", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        hist = '{0, 0, 0, 0};
        #2;
        doReset(10);

        runConversion(22, 0, 0);
        runConversion(39, 20, 10);
        runConversion(FULL, 0, 0);
        runConversion(-1, 0, 0);

        runConversion(19, 0, 0);
        runConversion(23, 0, 0);
        runConversion(27, 0, 0);
        runConversion(31, 0, 0);
        checkOutput("avg_fourth", obs_value, AVG_FOURTH);

        randomConversions(8);

        runConversion(30, 0, 0);
        abortConversion();

        randomConversions(3);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
